fifo_ram_ctrl: RTL

//   Sync FIFO controller directly upstream of the 16x8 dual-port RAM (registered read, 1-cycle latency).

---
 rtl/fifo_ram_ctrl_if.sv | 39 +++
 rtl/fifo_ram_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl_if.sv
// Handshake bundle between the FIFO controller, its stream neighbours and the 16x8 registered-read RAM.
// The slave side is the controller; the master side is everything around it (producer, consumer, RAM).
interface fifo_ram_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;

   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;

   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata;

   logic [AW+1:0] count;
   logic          empty;
   logic          full;

   modport slave (
      input  s_valid, s_data, m_ready, ram_rdata,
      output s_ready, m_valid, m_data,
      output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
      output count, empty, full
   );

   modport master (
      output s_valid, s_data, m_ready, ram_rdata,
      input  s_ready, m_valid, m_data,
      input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
      input  count, empty, full
   );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller in front of a registered-read dual-port RAM; a 2-entry
// output buffer absorbs the one-cycle read latency so the read side sustains 1 word/cycle.
module fifo_ram_ctrl #(
   parameter int DW    = 8,
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
   input logic            clk,
   input logic            rst,
   fifo_ram_ctrl_if.slave bus
);

   localparam logic [AW:0]   OCC_FULL   = (AW+1)'(DEPTH);
   localparam logic [AW+1:0] COUNT_FULL = (AW+2)'(DEPTH + 2);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_ram_occ;
   logic          r_inflight;
   logic [DW-1:0] r_obuf [2];
   logic [1:0]    r_obuf_cnt;

   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic [2:0]    w_pending;
   logic [DW-1:0] w_obuf_nxt [2];
   logic [1:0]    w_cnt_nxt;
   logic [AW+1:0] w_count;

   assign w_push = bus.s_valid & bus.s_ready;
   assign w_pop  = bus.m_valid & bus.m_ready;

   // Words already owed to the output buffer after this edge's pop; keep it below 2 so a landing always fits.
   assign w_pending = {1'b0, r_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue   = (r_ram_occ != '0) && (w_pending < 3'd2);

   always_comb begin
      w_obuf_nxt[0] = r_obuf[0];
      w_obuf_nxt[1] = r_obuf[1];
      w_cnt_nxt     = r_obuf_cnt;
      if (w_pop) begin
         w_obuf_nxt[0] = r_obuf[1];
         w_cnt_nxt     = r_obuf_cnt - 2'd1;
      end
      // The RAM result lands behind whatever survives the pop.
      if (r_inflight) begin
         if (w_cnt_nxt == 2'd0) begin
            w_obuf_nxt[0] = bus.ram_rdata;
         end else begin
            w_obuf_nxt[1] = bus.ram_rdata;
         end
         w_cnt_nxt = w_cnt_nxt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_ram_occ  <= '0;
         r_inflight <= 1'b0;
         r_obuf[0]  <= '0;
         r_obuf[1]  <= '0;
         r_obuf_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_issue) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_ram_occ <= r_ram_occ + (AW+1)'(1);
            2'b01:   r_ram_occ <= r_ram_occ - (AW+1)'(1);
            default: r_ram_occ <= r_ram_occ;
         endcase
         r_inflight <= w_issue;
         r_obuf[0]  <= w_obuf_nxt[0];
         r_obuf[1]  <= w_obuf_nxt[1];
         r_obuf_cnt <= w_cnt_nxt;
      end
   end

   assign w_count = {1'b0, r_ram_occ}
                  + {{(AW+1){1'b0}}, r_inflight}
                  + {{AW{1'b0}}, r_obuf_cnt};

   assign bus.s_ready   = (r_ram_occ < OCC_FULL);
   assign bus.m_valid   = (r_obuf_cnt != 2'd0);
   assign bus.m_data    = r_obuf[0];
   assign bus.ram_we    = w_push;
   assign bus.ram_waddr = r_wptr;
   assign bus.ram_wdata = bus.s_data;
   assign bus.ram_re    = w_issue;
   assign bus.ram_raddr = r_rptr;
   assign bus.count     = w_count;
   assign bus.empty     = (w_count == '0);
   assign bus.full      = (w_count == COUNT_FULL);

endmodule
